// File: rtl/systolic_result_drain_if.sv
// Row-stream interface carrying drained accumulator rows to the requant/writeback stage.
interface systolic_result_drain_if #(
    parameter int unsigned COLS  = 4,
    parameter int unsigned ROW_W = 2
);
    logic                  out_valid;
    logic                  out_ready;
    logic [COLS-1:0][31:0] out_data;
    logic [ROW_W-1:0]      out_row_idx;

    modport master (
        output out_valid,
        output out_data,
        output out_row_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_row_idx,
        output out_ready
    );
endinterface

// File: rtl/systolic_result_drain.sv
// Shifts finished accumulators out of the bottom of a PE array, one row per cycle,
// buffering captured rows in a small FIFO ahead of a valid/ready row stream.
module systolic_result_drain #(
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    load_sum,
    output logic                    zero_operands,
    output logic [COLS-1:0][31:0]   top_sum_in,
    input  logic [COLS-1:0][31:0]   col_sum_in,
    systolic_result_drain_if.master out_if
);
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]                               state_q, state_d;
    logic [ROW_W-1:0]                         shift_cnt_q, shift_cnt_d;
    logic                                     busy_q, busy_d;
    logic                                     done_q, done_d;
    logic [PTR_W-1:0]                         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                         count_q, count_d;
    logic [FIFO_DEPTH-1:0][COLS-1:0][31:0]    mem_data_q, mem_data_d;
    logic [FIFO_DEPTH-1:0][ROW_W-1:0]         mem_idx_q, mem_idx_d;

    logic pop;
    logic shift;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A full FIFO may still accept a row if its head leaves in the same cycle.
    assign pop   = (count_q != '0) && out_if.out_ready;
    assign shift = (state_q == ST_DRAIN) && ((count_q < CNT_W'(FIFO_DEPTH)) || pop);

    always_comb begin
        state_d     = state_q;
        shift_cnt_d = shift_cnt_q;
        done_d      = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_data_d  = mem_data_q;
        mem_idx_d   = mem_idx_q;

        case (state_q)
            ST_IDLE: begin
                // A start coinciding with the done pulse is dropped.
                if (start && !done_q) begin
                    state_d     = ST_DRAIN;
                    shift_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                if (shift) begin
                    if (shift_cnt_q == ROW_W'(ROWS - 1)) begin
                        state_d = ST_FLUSH;
                    end else begin
                        shift_cnt_d = shift_cnt_q + ROW_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (pop && (count_q == CNT_W'(1))) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Bottom-row value is only valid during the shift cycle; capture it at that edge.
        if (shift) begin
            mem_data_d[wr_ptr_q] = col_sum_in;
            mem_idx_d[wr_ptr_q]  = ROW_W'(ROWS - 1) - shift_cnt_q;
            wr_ptr_d             = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        count_d = count_q + CNT_W'(shift) - CNT_W'(pop);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mem_data_q  <= '0;
            mem_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            shift_cnt_q <= shift_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_data_q  <= mem_data_d;
            mem_idx_q   <= mem_idx_d;
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign zero_operands      = busy_q;
    assign load_sum           = shift;
    assign top_sum_in         = '0;
    assign out_if.out_valid   = (count_q != '0);
    assign out_if.out_data    = mem_data_q[rd_ptr_q];
    assign out_if.out_row_idx = mem_idx_q[rd_ptr_q];
endmodule

// File: tb/tb_systolic_result_drain.sv
// Bench for systolic_result_drain: a simple PE-array column model plus a row scoreboard.
module tb_systolic_result_drain;
    localparam int unsigned ROWS       = 4;
    localparam int unsigned COLS       = 4;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned ROW_W      = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  load_sum;
    logic                  zero_operands;
    logic [COLS-1:0][31:0] top_sum_in;
    logic [COLS-1:0][31:0] col_sum_in;

    systolic_result_drain_if #(.COLS(COLS), .ROW_W(ROW_W)) out_if ();

    systolic_result_drain #(
        .ROWS(ROWS), .COLS(COLS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .load_sum     (load_sum),
        .zero_operands(zero_operands),
        .top_sum_in   (top_sum_in),
        .col_sum_in   (col_sum_in),
        .out_if       (out_if)
    );

    always #5 clk = ~clk;

    // PE accumulator array: shifts down on load_sum, row 0 takes top_sum_in.
    logic [COLS-1:0][31:0] acc     [ROWS];
    logic [COLS-1:0][31:0] pre_val [ROWS];
    logic                  preload_req;

    always @(posedge clk) begin
        if (preload_req) begin
            acc <= pre_val;
        end else if (load_sum === 1'b1) begin
            for (int r = ROWS - 1; r > 0; r--) acc[r] <= acc[r-1];
            acc[0] <= top_sum_in;
        end
    end
    assign col_sum_in = acc[ROWS-1];

    typedef struct {
        logic [COLS-1:0][31:0] data;
        logic [ROW_W-1:0]      idx;
    } beat_t;
    beat_t exp_q[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ls_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          beats = 0;
    int          first_valid_cyc = -1;
    logic [31:0] first_lane0 = '0;
    logic [31:0] first_idx = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: every valid head must equal the oldest expected row.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            checks++;
            if (top_sum_in !== '0) begin
                errors++;
                $display("FAIL top_sum_in: got %h expected 0", top_sum_in);
            end
            if (out_if.out_valid === 1'b1) begin
                if (first_valid_cyc < 0) begin
                    first_valid_cyc = cyc;
                    first_lane0     = out_if.out_data[0];
                    first_idx       = 32'(out_if.out_row_idx);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got row %0d data %h, expected no beat",
                             out_if.out_row_idx, out_if.out_data);
                end else begin
                    if (out_if.out_data !== exp_q[0].data || out_if.out_row_idx !== exp_q[0].idx) begin
                        errors++;
                        $display("FAIL beat_data: got row %0d data %h, expected row %0d data %h",
                                 out_if.out_row_idx, out_if.out_data, exp_q[0].idx, exp_q[0].data);
                    end
                    if (out_if.out_ready === 1'b1) begin
                        exp_q.delete(0);
                        beats++;
                    end
                end
            end
            if (load_sum === 1'b1) ls_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [COLS*32-1:0] act,
                           input logic [COLS*32-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fill(input int mode);
        logic [31:0] v;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                v = 32'(100 * r + c);
                if (mode == 2) v = 32'(1000 + 100 * r + c);
                if (mode == 1) begin
                    v = 32'hA500_0000 | 32'((r << 8) | c);
                    if (c == 0) begin
                        case (r)
                            3:       v = 32'h8000_0000;
                            2:       v = 32'h7FFF_FFFF;
                            1:       v = 32'hFFFF_FFFF;
                            default: v = 32'h0000_0000;
                        endcase
                    end
                end
                pre_val[r][c] = v;
            end
        end
    endtask

    task automatic preload(input int mode);
        fill(mode);
        preload_req = 1'b1;
        tick();
        preload_req = 1'b0;
    endtask

    // Accepted drain: expect current array rows, bottom row first.
    task automatic pulse_start(input bit accept);
        start = 1'b1;
        if (accept) begin
            for (int k = 0; k < ROWS; k++) begin
                beat_t b;
                b.data = acc[ROWS-1-k];
                b.idx  = ROW_W'(ROWS - 1 - k);
                exp_q.push_back(b);
            end
        end
        tick();
        start = 1'b0;
    endtask

    task automatic clear_marks();
        ls_cnt          = 0;
        done_cnt        = 0;
        beats           = 0;
        done_cyc        = -1;
        first_valid_cyc = -1;
    endtask

    task automatic wait_done(input string name, input int target, input int budget);
        for (int i = 0; i < budget && done_cnt < target; i++) tick();
        chk(name, 32'(done_cnt >= target), 1);
    endtask

    int t;

    initial begin
        reset            = 1'b1;
        start            = 1'b0;
        preload_req      = 1'b0;
        out_if.out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_load_sum", 32'(load_sum), 0);
        chk("rst_zero_operands", 32'(zero_operands), 0);
        chk("rst_out_valid", 32'(out_if.out_valid), 0);
        chk_vec("rst_out_data", out_if.out_data, '0);
        chk("rst_out_row_idx", 32'(out_if.out_row_idx), 0);

        // Idle: nothing moves without start
        for (int i = 0; i < 20; i++) begin
            chk("idle_load_sum", 32'(load_sum), 0);
            chk("idle_zero_operands", 32'(zero_operands), 0);
            chk("idle_out_valid", 32'(out_if.out_valid), 0);
            chk("idle_done", 32'(done), 0);
            chk_vec("idle_top_sum_in", top_sum_in, '0);
            tick();
        end

        // Basic drain, ready held high
        out_if.out_ready = 1'b1;
        preload(0);
        clear_marks();
        t = cyc;
        pulse_start(1);
        chk("basic_busy_after_start", 32'(busy), 1);
        chk("basic_zero_operands", 32'(zero_operands), 1);
        wait_done("basic_done_seen", 1, 20);
        chk("basic_done_latency", 32'(done_cyc - t), 6);
        chk("basic_first_valid_latency", 32'(first_valid_cyc - t), 2);
        chk("basic_first_lane0", first_lane0, 300);
        chk("basic_first_row_idx", first_idx, 3);
        chk("basic_load_sum_pulses", 32'(ls_cnt), 4);
        chk("basic_beats", 32'(beats), 4);
        chk("basic_exp_empty", 32'(exp_q.size()), 0);
        chk("basic_busy_end", 32'(busy), 0);
        for (int r = 0; r < ROWS; r++) chk_vec("basic_array_cleared", acc[r], '0);

        // Backpressure: ready low, FIFO of 2 fills and the shift stalls
        out_if.out_ready = 1'b0;
        preload(0);
        clear_marks();
        pulse_start(1);
        repeat (8) tick();
        chk("bp_load_sum_pulses", 32'(ls_cnt), 2);
        chk("bp_load_sum_low", 32'(load_sum), 0);
        chk("bp_array_held_r3", acc[3][1], 101);
        chk("bp_array_held_r2", acc[2][1], 1);
        chk("bp_busy", 32'(busy), 1);
        chk("bp_out_valid", 32'(out_if.out_valid), 1);
        chk("bp_head_row_idx", 32'(out_if.out_row_idx), 3);
        out_if.out_ready = 1'b1;
        wait_done("bp_done_seen", 1, 30);
        chk("bp_beats", 32'(beats), 4);
        chk("bp_load_sum_total", 32'(ls_cnt), 4);
        chk("bp_exp_empty", 32'(exp_q.size()), 0);

        // Alternating ready on a full FIFO, extreme int32 values
        out_if.out_ready = 1'b0;
        preload(1);
        clear_marks();
        pulse_start(1);
        repeat (4) tick();
        chk("alt_filled_shifts", 32'(ls_cnt), 2);
        for (int i = 0; i < 16 && done_cnt == 0; i++) begin
            out_if.out_ready = ((i % 2) == 0);
            #1;
            if (i < 3) begin
                chk("alt_shift_follows_pop", 32'(load_sum), 32'(((i % 2) == 0)));
                chk("alt_full_valid", 32'(out_if.out_valid), 1);
            end
            tick();
        end
        out_if.out_ready = 1'b1;
        wait_done("alt_done_seen", 1, 20);
        chk("alt_first_lane0", first_lane0, 32'h8000_0000);
        chk("alt_beats", 32'(beats), 4);
        chk("alt_load_sum_total", 32'(ls_cnt), 4);
        chk("alt_exp_empty", 32'(exp_q.size()), 0);

        // Start during DRAIN and in the done cycle is ignored; next cycle is accepted
        out_if.out_ready = 1'b1;
        preload(0);
        clear_marks();
        t = cyc;
        pulse_start(1);
        tick();
        pulse_start(0);
        repeat (3) tick();
        fill(2);
        start       = 1'b1;
        preload_req = 1'b1;
        tick();
        start       = 1'b0;
        preload_req = 1'b0;
        chk("restart_done_latency", 32'(done_cyc - t), 6);
        chk("restart_done_count", 32'(done_cnt), 1);
        first_valid_cyc = -1;
        pulse_start(1);
        wait_done("restart_done_seen", 2, 20);
        chk("restart_first_valid", 32'(first_valid_cyc - t), 9);
        chk("restart_first_lane0", first_lane0, 1300);
        chk("restart_load_sum_total", 32'(ls_cnt), 8);
        chk("restart_beats", 32'(beats), 8);
        chk("restart_exp_empty", 32'(exp_q.size()), 0);

        // Reset after the second shift, then drain the partially shifted array
        out_if.out_ready = 1'b0;
        preload(0);
        clear_marks();
        pulse_start(1);
        repeat (6) tick();
        chk("rstmid_shifts_before", 32'(ls_cnt), 2);
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_out_valid", 32'(out_if.out_valid), 0);
        chk("rstmid_load_sum", 32'(load_sum), 0);
        repeat (10) tick();
        chk("rstmid_no_done", 32'(done_cnt), 0);
        chk("rstmid_no_shift", 32'(ls_cnt), 2);
        out_if.out_ready = 1'b1;
        first_valid_cyc  = -1;
        pulse_start(1);
        wait_done("rstmid_done_seen", 1, 20);
        chk("rstmid_first_lane0", first_lane0, 100);
        chk("rstmid_first_row_idx", first_idx, 3);
        chk("rstmid_beats", 32'(beats), 4);
        chk("rstmid_load_sum_total", 32'(ls_cnt), 6);
        chk("rstmid_exp_empty", 32'(exp_q.size()), 0);
        for (int r = 0; r < ROWS; r++) chk_vec("rstmid_array_cleared", acc[r], '0);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Unloads finished int32 accumulators from a ROWS x COLS tensor PE array after a matrix tile completes.
- Drives the array's shared load_sum and feeds zero into the top of each column, so the accumulator chain shifts down one row per cycle.
- Captures the bottom-row sum_out of every column, buffers captured rows in a small FIFO, and presents them downstream over a valid/ready stream.
- Sits between the PE array and the requantization/writeback stage.

Parameters:
- ROWS, 4, PEs per column chain (rows to drain); >= 1.
- COLS, 4, columns drained in parallel (int32 lanes per output beat); >= 1.
- FIFO_DEPTH, 4, row-buffer entries; >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to drain the array; ignored while busy
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last row is accepted downstream
- load_sum  out  1  to every PE; high = shift accumulator chain one row down
- zero_operands  out  1  to operand feeders; high = drive all left_in/top_in to 0
- top_sum_in  out  32xCOLS  sum_in for the row-0 PEs; constant 0
- col_sum_in  in  32xCOLS  sum_out of the bottom-row PE of each column (int32 each)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accept
- out_data  out  32xCOLS  FIFO head row; lane c = column c
- out_row_idx  out  clog2(ROWS) (min 1)  array row index of out_data

Behaviour:
- Reset values: state IDLE, all counters 0, FIFO empty, busy=0, done=0, load_sum=0, zero_operands=0, out_valid=0, out_data=0, out_row_idx=0. top_sum_in is always 0.
- States:
  - IDLE: start=1 -> DRAIN, with shift counter = 0.
  - DRAIN: leave for FLUSH on the cycle the ROWS-th shift occurs.
  - FLUSH: FIFO becomes empty (last pop) -> IDLE, and done pulses in that same transition cycle.
- busy = (state != IDLE); zero_operands = busy. While operands are zero, PE accumulators hold value when load_sum=0.
- Shift condition: shift = (state==DRAIN) && (fifo_count < FIFO_DEPTH || pop). load_sum = shift, combinational.
- Capture: on a shift cycle, col_sum_in is sampled and pushed into the FIFO at the same clk edge at which the PEs shift.
  - The value present during a load_sum cycle is the bottom row's accumulator; it is lost after that edge, so it must be captured then.
- Row order: capture k (k = 0..ROWS-1) corresponds to array row ROWS-1-k and is stored with row_idx = ROWS-1-k. Rows are emitted bottom row first.
- After ROWS shifts, every PE accumulator holds 0, because zero enters from the top. The array is ready for the next tile with no separate clear.
- FIFO: in-order, FIFO_DEPTH entries of {COLS x int32, row_idx}.
  - pop = out_valid && out_ready.
  - out_valid = (count != 0); out_data and out_row_idx reflect the head entry.
  - Simultaneous push and pop: count unchanged, head advances.
  - Full with no pop: shift stalls (load_sum=0); array contents hold.
  - Empty: out_valid=0, out_data holds its last value (don't care).
- Latency:
  - start at cycle t -> first load_sum at t+1 (the FIFO is empty then).
  - out_valid rises at t+2.
  - With out_ready held high: one row per cycle, done at t+ROWS+2.
- Data is passed through bit-exact; no arithmetic on int32 values, no saturation.
- start while busy: ignored, with no effect on the counters. start in the done cycle: ignored; accepted from the following cycle.
- Reset mid-operation: returns to IDLE and discards the FIFO. load_sum drops immediately, so the array keeps any partially shifted contents. Software must re-drain or the array must be reset.
- done is never asserted without a preceding accepted start.

Test Plan:
- Basic drain, ROWS=4, COLS=4, out_ready=1: preload accumulators with row r, col c = 100*r+c, pulse start. Expect beats rows 3,2,1,0 (lane c of row 3 = 300+c) on 4 consecutive cycles, out_row_idx 3,2,1,0, done 6 cycles after start, all PEs = 0 afterwards.
- Backpressure with out_ready=0 throughout, FIFO_DEPTH=2: expect exactly 2 load_sum pulses, then load_sum=0 and held array contents. Release ready and expect the remaining rows in order with no duplicates or drops.
- Alternating out_ready (1,0,1,0...) with full FIFO: push/pop in the same cycle keeps count constant. Data values and order (e.g. -2147483648, 2147483647, -1, 0 in lane 0) come out bit-exact.
- start asserted again during DRAIN and in the done cycle: ignored. A start one cycle after done begins a new drain, and its first beat appears 2 cycles later.
- Reset asserted after the 2nd shift: next cycle busy=0, out_valid=0, load_sum=0, done never pulses. A subsequent start drains the remaining ROWS rows normally.
- Idle check: with no start for 20 cycles, load_sum, zero_operands, out_valid and done all stay 0, and top_sum_in stays 0.
